rh_dbuf: RTL and testbench
==========================

RH_DBUF -- requirements
Module: rh_dbuf

Interface
- REQ-001 SHALL have parameter: DEPTH, 4, buffer depth in 36-bit words; power of two, 2..16.
- REQ-002 SHALL have port: clk  in  1  clock; all logic on rising edge.
- REQ-003 SHALL have port: rst  in  1  asynchronous active-low reset.
- REQ-004 SHALL have ports: devRESET  in  1  UBA device reset; rhCLR  in  1  controller clear; rhGO  in  1  start-transfer pulse.
- REQ-005 SHALL have ports: mbDIR  in  1  1 = disk write (memory to disk), 0 = disk read; rhWCMODE  in  1  write-check mode, sampled with rhGO.
- REQ-006 SHALL have ports: ubWR  in  1  memory-side push/compare strobe; ubWDATA  in  36  memory word; ubRD  in  1  memory-side pop; ubRDATA  out  36  head word.
- REQ-007 SHALL have ports: mbSTB  in  1  disk word strobe, not stallable; mbWDATA  in  36  disk-read word; mbRDATA  out  36  head word, 0 when empty.
- REQ-008 SHALL have ports: rhBUFIR  out  1  buffer not full; rhBUFOR  out  1  buffer not empty; rhSETDLT  out  1  data-late pulse; rhSETWCE  out  1  write-check-error pulse; rhCOUNT  out  $clog2(DEPTH)+1  words held.

Function
- REQ-009 SHALL implement a first-word-fall-through circular buffer; ubRDATA and mbRDATA show the head word combinationally.
- REQ-010 SHALL have states IDLE, XFER, HALT; IDLE to XFER on rhGO; XFER to HALT on a DLT or WCE event; HALT to XFER on rhGO; any state to IDLE on devRESET or rhCLR.
- REQ-011 SHALL empty the buffer (pointers and count to 0) on rhGO, devRESET or rhCLR, in the same cycle the strobe is sampled.
- REQ-012 SHALL, in XFER with mbDIR=0 and WC off: mbSTB pushes mbWDATA and ubRD pops.
- REQ-013 SHALL, in XFER with mbDIR=1: ubWR pushes ubWDATA and mbSTB pops.
- REQ-014 SHALL, in read mode, allow a pop and an mbSTB push in the same cycle when full; the pop takes effect first, the push is accepted and no DLT is raised.
- REQ-015 SHALL, in write mode, not bypass an empty buffer: a simultaneous ubWR and mbSTB when empty raises DLT and stores the ubWR word.
- REQ-016 SHALL, on mbSTB to a full buffer (read/WC) or an empty buffer (write), drop the transfer, pulse rhSETDLT for exactly 1 cycle and enter HALT.
- REQ-017 SHALL ignore ubWR when full, ubRD when empty, and all strobes in IDLE/HALT, with no error raised.
- REQ-018 SHALL keep rhCOUNT in 0..DEPTH with pointer wrap modulo DEPTH; rhBUFIR = (rhCOUNT != DEPTH) and rhBUFOR = (rhCOUNT != 0), both registered-count derived.
- REQ-019 SHALL hold rhSETDLT and rhSETWCE low except during the single event cycle; they are not sticky.

Reset
- REQ-020 SHALL, on rst=0, force state IDLE, pointers 0, rhCOUNT 0, rhBUFIR 1, rhBUFOR 0, rhSETDLT 0, rhSETWCE 0, mbRDATA 0; buffer RAM contents are not reset.
- REQ-021 SHALL, on devRESET or rhCLR mid-transfer, abandon the transfer with no DLT/WCE pulse.

Configuration
- REQ-022 SHALL compile write-check support only when macro RH_DBUF_WCE_EN is defined.
- REQ-023 SHALL, with RH_DBUF_WCE_EN defined and rhWCMODE latched 1 in XFER, behave as follows: mbSTB pushes disk words; ubWR compares ubWDATA to the head word and pops it when not empty. On mismatch it pulses rhSETWCE for 1 cycle and enters HALT.
- REQ-024 SHALL, without RH_DBUF_WCE_EN, ignore rhWCMODE (treated as 0) and tie rhSETWCE to 0.

Structure
- REQ-025 SHALL place the state enumeration (IDLE/XFER/HALT) and the DEPTH limits in shared package rh_dbuf_pkg.
- REQ-026 SHALL instantiate one sub-module rh_dbuf_ram: DEPTH x 36 register array, one synchronous write port, one asynchronous read port.

Verification
- REQ-027 SHALL cover read fill: GO, mbDIR=0, 5 mbSTB with no ubRD, DEPTH=4 -> rhCOUNT reaches 4, rhBUFIR=0, 5th strobe gives rhSETDLT pulse, state HALT.
- REQ-028 SHALL cover write underrun: GO, mbDIR=1, ubWR 0o123456701234 then 2 mbSTB -> mbRDATA=0o123456701234 on strobe 1, rhSETDLT on strobe 2.
- REQ-029 SHALL cover full-boundary concurrency: count=4 read mode, mbSTB and ubRD same cycle -> count stays 4, no DLT, ubRDATA advances.
- REQ-030 SHALL cover write check (RH_DBUF_WCE_EN): disk pushes 0o1 and 0o2, ubWR 0o1 then 0o3 -> no error on word 1, rhSETWCE pulse on word 2, HALT.
- REQ-031 SHALL cover wrap and reset: 10 push/pop pairs at DEPTH=4 -> data in order across wrap; rhCLR with count=3 -> count 0, IDLE, no pulses; rst=0 -> all REQ-020 values.

Source files
------------

// File: rtl/rh_dbuf_pkg.sv
// Shared definitions for the RH disk data buffer: word width, depth limits and
// the transfer-control state encoding.
package rh_dbuf_pkg;

  localparam int WORD_W    = 36;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/rh_dbuf_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous
// read port feeding the fall-through head word.
module rh_dbuf_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; the pointers and count define which words are
  // valid, so clearing the array would only cost a reset net per bit.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rh_dbuf.sv
// RH disk data buffer: fall-through circular buffer between UBA memory side and
// MASSBUS disk side with data-late detection. Write-check compare is built only
// when RH_DBUF_WCE_EN is defined.
module rh_dbuf
  import rh_dbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     devRESET,
  input  logic                     rhCLR,
  input  logic                     rhGO,
  input  logic                     mbDIR,
  input  logic                     rhWCMODE,
  input  logic                     ubWR,
  input  logic [WORD_W-1:0]        ubWDATA,
  input  logic                     ubRD,
  output logic [WORD_W-1:0]        ubRDATA,
  input  logic                     mbSTB,
  input  logic [WORD_W-1:0]        mbWDATA,
  output logic [WORD_W-1:0]        mbRDATA,
  output logic                     rhBUFIR,
  output logic                     rhBUFOR,
  output logic                     rhSETDLT,
  output logic                     rhSETWCE,
  output logic [$clog2(DEPTH):0]   rhCOUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rh_dbuf: DEPTH must be a power of two in 2..16");
  end

  state_t            r_state, w_state_nxt;
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [WORD_W-1:0] w_head, w_wdata;
  logic              w_abort, w_clear, w_active, w_full, w_empty;
  logic              w_wc, w_push, w_pop, w_dlt, w_wce;

  assign w_abort  = devRESET | rhCLR;
  assign w_clear  = w_abort | rhGO;
  assign w_active = (r_state == XFER) && !w_clear;
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);

`ifdef RH_DBUF_WCE_EN
  logic r_wcmode;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_wcmode <= 1'b0;
    else if (w_abort) r_wcmode <= 1'b0;
    else if (rhGO)    r_wcmode <= rhWCMODE;
  end

  assign w_wc     = r_wcmode;
  assign rhSETWCE = w_wce;
`else
  logic w_unused_wcmode;

  assign w_unused_wcmode = rhWCMODE;
  assign w_wc            = 1'b0;
  assign rhSETWCE        = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch can be inferred.
  always_comb begin
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_wdata = mbWDATA;
    w_dlt   = 1'b0;
    w_wce   = 1'b0;
    if (w_active) begin
      if (mbDIR && !w_wc) begin
        // Disk write: the disk strobe can never be served from an empty buffer.
        w_wdata = ubWDATA;
        w_push  = ubWR && !w_full;
        w_pop   = mbSTB && !w_empty;
        w_dlt   = mbSTB && w_empty;
      end else begin
        // Disk read or write-check: a same-cycle pop frees room for the strobe.
        w_pop  = (w_wc ? ubWR : ubRD) && !w_empty;
        w_push = mbSTB && (!w_full || w_pop);
        w_dlt  = mbSTB && w_full && !w_pop;
        w_wce  = w_wc && w_pop && (ubWDATA != w_head);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort)                                   w_state_nxt = IDLE;
    else if (rhGO)                                 w_state_nxt = XFER;
    else if ((r_state == XFER) && (w_dlt || w_wce)) w_state_nxt = HALT;
  end

  rh_dbuf_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  assign ubRDATA  = w_head;
  assign mbRDATA  = w_empty ? '0 : w_head;
  assign rhBUFIR  = !w_full;
  assign rhBUFOR  = !w_empty;
  assign rhSETDLT = w_dlt;
  assign rhCOUNT  = r_count;

endmodule

// File: tb/tb_rh_dbuf.sv
// Directed bench for rh_dbuf (DEPTH=4): vector table plus hand sequences for
// wrap, write-check and asynchronous reset.
module tb_rh_dbuf;
  import rh_dbuf_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, devRESET, rhCLR, rhGO, mbDIR, rhWCMODE;
  logic        ubWR, ubRD, mbSTB;
  logic [35:0] ubWDATA, mbWDATA, ubRDATA, mbRDATA;
  logic        rhBUFIR, rhBUFOR, rhSETDLT, rhSETWCE;
  logic [2:0]  rhCOUNT;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic        go, clr, dev, dir, wcm, ubwr;
    logic [35:0] ubwd;
    logic        ubrd, stb;
    logic [35:0] mbwd;
    logic        e_dlt, e_wce;
    logic [35:0] e_mb;
    logic        chk_ub;
    int          e_cnt;
    state_t      e_st;
  } vec_t;

  rh_dbuf #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .devRESET (devRESET),
    .rhCLR    (rhCLR),
    .rhGO     (rhGO),
    .mbDIR    (mbDIR),
    .rhWCMODE (rhWCMODE),
    .ubWR     (ubWR),
    .ubWDATA  (ubWDATA),
    .ubRD     (ubRD),
    .ubRDATA  (ubRDATA),
    .mbSTB    (mbSTB),
    .mbWDATA  (mbWDATA),
    .mbRDATA  (mbRDATA),
    .rhBUFIR  (rhBUFIR),
    .rhBUFOR  (rhBUFOR),
    .rhSETDLT (rhSETDLT),
    .rhSETWCE (rhSETWCE),
    .rhCOUNT  (rhCOUNT)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic go, clr, dev, dir, wcm, ubwr,
                              input logic [35:0] ubwd, input logic ubrd, stb,
                              input logic [35:0] mbwd, input logic e_dlt, e_wce,
                              input logic [35:0] e_mb, input logic chk_ub,
                              input int e_cnt, input state_t e_st);
    vec_t v;
    v.name = nm; v.go = go; v.clr = clr; v.dev = dev; v.dir = dir; v.wcm = wcm;
    v.ubwr = ubwr; v.ubwd = ubwd; v.ubrd = ubrd; v.stb = stb; v.mbwd = mbwd;
    v.e_dlt = e_dlt; v.e_wce = e_wce; v.e_mb = e_mb; v.chk_ub = chk_ub;
    v.e_cnt = e_cnt; v.e_st = e_st;
    return v;
  endfunction

  // Pulses and head words are checked before the edge, count/state after it.
  task automatic step(input vec_t v);
    @(negedge clk);
    rhGO = v.go; rhCLR = v.clr; devRESET = v.dev; mbDIR = v.dir; rhWCMODE = v.wcm;
    ubWR = v.ubwr; ubWDATA = v.ubwd; ubRD = v.ubrd; mbSTB = v.stb; mbWDATA = v.mbwd;
    #1;
    check({v.name, " dlt"}, 36'(rhSETDLT), 36'(v.e_dlt));
    check({v.name, " wce"}, 36'(rhSETWCE), 36'(v.e_wce));
    check({v.name, " mbRDATA"}, mbRDATA, v.e_mb);
    if (v.chk_ub) check({v.name, " ubRDATA"}, ubRDATA, v.e_mb);
    @(posedge clk);
    #1;
    check({v.name, " count"}, 36'(rhCOUNT), 36'(v.e_cnt));
    check({v.name, " bufir"}, 36'(rhBUFIR), 36'(v.e_cnt != DEPTH));
    check({v.name, " bufor"}, 36'(rhBUFOR), 36'(v.e_cnt != 0));
    check({v.name, " state"}, 36'(dut.r_state), 36'(v.e_st));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " count"}, 36'(rhCOUNT), 36'd0);
    check({tag, " bufir"}, 36'(rhBUFIR), 36'd1);
    check({tag, " bufor"}, 36'(rhBUFOR), 36'd0);
    check({tag, " dlt"}, 36'(rhSETDLT), 36'd0);
    check({tag, " wce"}, 36'(rhSETWCE), 36'd0);
    check({tag, " mbRDATA"}, mbRDATA, 36'd0);
    check({tag, " state"}, 36'(dut.r_state), 36'(IDLE));
  endtask

  logic [35:0] w [8];
  logic [35:0] wo;
  vec_t        vecs[$];

  initial begin
    rst = 1'b0; devRESET = 1'b0; rhCLR = 1'b0; rhGO = 1'b0; mbDIR = 1'b0; rhWCMODE = 1'b0;
    ubWR = 1'b0; ubRD = 1'b0; mbSTB = 1'b0; ubWDATA = '0; mbWDATA = '0;
    for (int i = 0; i < 8; i++) w[i] = 36'h9_0000_0000 + 36'(i) * 36'h0_0101_0101;
    wo = 36'o123456701234;

    //                 name          go clr dev dir wcm ubwr ubwd  ubrd stb mbwd  dlt wce e_mb  chk cnt st
    vecs.push_back(mk("idle_stb",     0, 0, 0, 0, 0, 0, '0,   0, 1, w[0], 0, 0, '0,   0, 0, IDLE));
    vecs.push_back(mk("go_rd",        1, 0, 0, 0, 0, 0, '0,   0, 0, '0,   0, 0, '0,   0, 0, XFER));
    vecs.push_back(mk("fill1",        0, 0, 0, 0, 0, 0, '0,   0, 1, w[1], 0, 0, '0,   0, 1, XFER));
    vecs.push_back(mk("fill2",        0, 0, 0, 0, 0, 0, '0,   0, 1, w[2], 0, 0, w[1], 1, 2, XFER));
    vecs.push_back(mk("fill3",        0, 0, 0, 0, 0, 0, '0,   0, 1, w[3], 0, 0, w[1], 1, 3, XFER));
    vecs.push_back(mk("fill4",        0, 0, 0, 0, 0, 0, '0,   0, 1, w[4], 0, 0, w[1], 1, 4, XFER));
    vecs.push_back(mk("fill5_dlt",    0, 0, 0, 0, 0, 0, '0,   0, 1, w[5], 1, 0, w[1], 1, 4, HALT));
    vecs.push_back(mk("halt_ign",     0, 0, 0, 0, 0, 0, '0,   1, 1, w[6], 0, 0, w[1], 1, 4, HALT));
    vecs.push_back(mk("go_rd2",       1, 0, 0, 0, 0, 0, '0,   0, 0, '0,   0, 0, w[1], 1, 0, XFER));
    vecs.push_back(mk("refill1",      0, 0, 0, 0, 0, 0, '0,   0, 1, w[1], 0, 0, '0,   0, 1, XFER));
    vecs.push_back(mk("refill2",      0, 0, 0, 0, 0, 0, '0,   0, 1, w[2], 0, 0, w[1], 1, 2, XFER));
    vecs.push_back(mk("refill3",      0, 0, 0, 0, 0, 0, '0,   0, 1, w[3], 0, 0, w[1], 1, 3, XFER));
    vecs.push_back(mk("refill4",      0, 0, 0, 0, 0, 0, '0,   0, 1, w[4], 0, 0, w[1], 1, 4, XFER));
    vecs.push_back(mk("full_concur",  0, 0, 0, 0, 0, 0, '0,   1, 1, w[5], 0, 0, w[1], 1, 4, XFER));
    vecs.push_back(mk("pop_adv",      0, 0, 0, 0, 0, 0, '0,   1, 0, '0,   0, 0, w[2], 1, 3, XFER));
    vecs.push_back(mk("clr_cnt3",     0, 1, 0, 0, 0, 0, '0,   0, 1, w[6], 0, 0, w[3], 1, 0, IDLE));
    vecs.push_back(mk("go_wr",        1, 0, 0, 1, 0, 0, '0,   0, 0, '0,   0, 0, '0,   0, 0, XFER));
    vecs.push_back(mk("wr_ubwr",      0, 0, 0, 1, 0, 1, wo,   0, 0, '0,   0, 0, '0,   0, 1, XFER));
    vecs.push_back(mk("wr_stb1",      0, 0, 0, 1, 0, 0, '0,   0, 1, '0,   0, 0, wo,   1, 0, XFER));
    vecs.push_back(mk("wr_stb2_dlt",  0, 0, 0, 1, 0, 0, '0,   0, 1, '0,   1, 0, '0,   0, 0, HALT));
    vecs.push_back(mk("go_wr2",       1, 0, 0, 1, 0, 0, '0,   0, 0, '0,   0, 0, '0,   0, 0, XFER));
    vecs.push_back(mk("wr_no_bypass", 0, 0, 0, 1, 0, 1, w[7], 0, 1, '0,   1, 0, '0,   0, 1, HALT));
    vecs.push_back(mk("dev_reset",    0, 0, 1, 1, 0, 0, '0,   0, 0, '0,   0, 0, w[7], 1, 0, IDLE));
    vecs.push_back(mk("go_wr3",       1, 0, 0, 1, 0, 0, '0,   0, 0, '0,   0, 0, '0,   0, 0, XFER));
    vecs.push_back(mk("wfill1",       0, 0, 0, 1, 0, 1, w[1], 0, 0, '0,   0, 0, '0,   0, 1, XFER));
    vecs.push_back(mk("wfill2",       0, 0, 0, 1, 0, 1, w[2], 0, 0, '0,   0, 0, w[1], 1, 2, XFER));
    vecs.push_back(mk("wfill3",       0, 0, 0, 1, 0, 1, w[3], 0, 0, '0,   0, 0, w[1], 1, 3, XFER));
    vecs.push_back(mk("wfill4",       0, 0, 0, 1, 0, 1, w[4], 0, 0, '0,   0, 0, w[1], 1, 4, XFER));
    vecs.push_back(mk("wfull_ign",    0, 0, 0, 1, 0, 1, w[5], 0, 0, '0,   0, 0, w[1], 1, 4, XFER));
    vecs.push_back(mk("wpop1",        0, 0, 0, 1, 0, 0, '0,   0, 1, '0,   0, 0, w[1], 1, 3, XFER));
    vecs.push_back(mk("wpop2",        0, 0, 0, 1, 0, 0, '0,   0, 1, '0,   0, 0, w[2], 1, 2, XFER));
    vecs.push_back(mk("wr_ubrd_ign",  0, 0, 0, 1, 0, 0, '0,   1, 0, '0,   0, 0, w[3], 1, 2, XFER));

    #1;
    check_reset_values("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Wrap: 10 push/pop pairs through a 4-deep buffer, data must stay in order.
    step(mk("wrap_go",   1, 0, 0, 0, 0, 0, '0, 0, 0, '0, 0, 0, w[3], 1, 0, XFER));
    step(mk("wrap_seed", 0, 0, 0, 0, 0, 0, '0, 0, 1, 36'h5_A5A5_0000, 0, 0, '0, 0, 1, XFER));
    for (int i = 1; i <= 10; i++)
      step(mk($sformatf("wrap%0d", i), 0, 0, 0, 0, 0, 0, '0, 1, 1, 36'h5_A5A5_0000 + 36'(i),
              0, 0, 36'h5_A5A5_0000 + 36'(i - 1), 1, 1, XFER));
    step(mk("wrap_last", 0, 0, 0, 0, 0, 0, '0, 1, 0, '0, 0, 0, 36'h5_A5A5_000A, 1, 0, XFER));

    // Asynchronous reset mid-transfer with a strobe held high.
    step(mk("pre_rst1", 0, 0, 0, 0, 0, 0, '0, 0, 1, w[1], 0, 0, '0,   0, 1, XFER));
    step(mk("pre_rst2", 0, 0, 0, 0, 0, 0, '0, 0, 1, w[2], 0, 0, w[1], 1, 2, XFER));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_values("rst_async");
    @(posedge clk);
    #1;
    check_reset_values("rst_held");
    @(negedge clk);
    rst = 1'b1;
    mbSTB = 1'b0;

`ifdef RH_DBUF_WCE_EN
    step(mk("wc_go",    1, 0, 0, 1, 1, 0, '0,     0, 0, '0,     0, 0, '0,     0, 0, XFER));
    step(mk("wc_disk1", 0, 0, 0, 1, 0, 0, '0,     0, 1, 36'o1,  0, 0, '0,     0, 1, XFER));
    step(mk("wc_disk2", 0, 0, 0, 1, 0, 0, '0,     0, 1, 36'o2,  0, 0, 36'o1,  1, 2, XFER));
    step(mk("wc_match", 0, 0, 0, 1, 0, 1, 36'o1,  0, 0, '0,     0, 0, 36'o1,  1, 1, XFER));
    step(mk("wc_miss",  0, 0, 0, 1, 0, 1, 36'o3,  0, 0, '0,     0, 1, 36'o2,  1, 0, HALT));
`else
    step(mk("nowc_go",   1, 0, 0, 0, 1, 0, '0,   0, 0, '0,   0, 0, '0,   0, 0, XFER));
    step(mk("nowc_push", 0, 0, 0, 0, 0, 0, '0,   0, 1, w[1], 0, 0, '0,   0, 1, XFER));
    step(mk("nowc_ubwr", 0, 0, 0, 0, 0, 1, w[2], 0, 0, '0,   0, 0, w[1], 1, 1, XFER));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
